scan_sequencer: RTL

Sequences full_scan acquisitions on sys_clk. Generates periodic send-sync pulses for the full_scan sync input, then tracks each acquisition until the scan reports frame completion. Flags overruns, where the period elapses while a scan is still busy, and timeouts, where a frame never completes. Sits between the control registers and full_scan as the sole driver of its sync input.

---
 rtl/scan_seq_pkg.sv | 18 +
 rtl/scan_period_timer.sv | 42 ++++
 rtl/scan_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan sequencer: FSM state encoding,
// minimum sync period and default parameter widths.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam int MIN_PERIOD = 4;

  localparam int DEF_PERIOD_W = 24;
  localparam int DEF_SYNC_LEN = 2;
  localparam int DEF_TIMEOUT  = 16000000;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/scan_period_timer.sv
// Free-running period timer: counts while en=1, emits a one-cycle tick every
// effective period (period clamped to MIN_PERIOD) and reloads to zero.
module scan_period_timer
  import scan_seq_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] last;

  always_comb begin
    eff_period = period;
    if (period < PERIOD_W'(MIN_PERIOD)) begin
      eff_period = PERIOD_W'(MIN_PERIOD);
    end
  end

  assign last = eff_period - PERIOD_W'(1);

  // >= rather than == so a period shortened below the current count fires
  // at the next compare instead of running the counter round its full range.
  assign tick = en && (cnt >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Drives full_scan's sync input and tracks each acquisition to completion,
// flagging overruns and timeouts. Optional macro: SCAN_SEQ_RDY_GATE_EN.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_single,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_frame_done,
  input  logic                i_st_rdy,
  output logic                o_send_sync,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_frame_cnt,
  output logic                o_overrun,
  output logic                o_timeout,
  output logic [1:0]          o_dbg_state
);

  localparam int SL_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [SL_W-1:0]     SYNC_LAST = SL_W'(SYNC_LEN - 1);
  localparam logic [PERIOD_W-1:0] TO_LAST   = PERIOD_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [SL_W-1:0]     sync_cnt, sync_cnt_nxt;
  logic [PERIOD_W-1:0] to_cnt, to_cnt_nxt;
  logic [CNT_W-1:0]    frame_cnt, frame_cnt_nxt;
  logic                timeout_q, timeout_nxt;
  logic                overrun;
  logic                tick;
  logic                start;
  logic                idle_overrun;

  scan_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (sys_clk),
    .rst    (rst),
    .en     (i_en),
    .period (i_period),
    .tick   (tick)
  );

`ifdef SCAN_SEQ_RDY_GATE_EN
  // A trigger seen while the stream is not ready is parked until it is.
  logic pend_tick, pend_tick_nxt;
  logic pend_single, pend_single_nxt;
  logic pending;

  assign pending      = pend_tick | pend_single;
  assign start        = (tick | i_single | pending) & i_st_rdy;
  assign idle_overrun = tick & pending;

  always_comb begin
    pend_tick_nxt   = pend_tick;
    pend_single_nxt = pend_single;
    if ((state != ST_IDLE) || start) begin
      pend_tick_nxt   = 1'b0;
      pend_single_nxt = 1'b0;
    end else begin
      if (tick && !pending) begin
        pend_tick_nxt = 1'b1;
      end
      if (i_single) begin
        pend_single_nxt = 1'b1;
      end
      if (!i_en) begin
        pend_tick_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pend_tick   <= 1'b0;
      pend_single <= 1'b0;
    end else begin
      pend_tick   <= pend_tick_nxt;
      pend_single <= pend_single_nxt;
    end
  end
`else
  logic unused_rdy;
  assign unused_rdy   = i_st_rdy;
  assign start        = tick | i_single;
  assign idle_overrun = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    sync_cnt_nxt  = sync_cnt;
    to_cnt_nxt    = to_cnt;
    frame_cnt_nxt = frame_cnt;
    timeout_nxt   = 1'b0;
    overrun       = 1'b0;
    case (state)
      ST_IDLE: begin
        overrun = idle_overrun;
        if (start) begin
          state_nxt    = ST_SYNC;
          sync_cnt_nxt = '0;
        end
      end
      ST_SYNC: begin
        overrun = tick;
        if (sync_cnt == SYNC_LAST) begin
          state_nxt  = ST_WAIT_DONE;
          to_cnt_nxt = '0;
        end else begin
          sync_cnt_nxt = sync_cnt + SL_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        overrun = tick;
        // Frame completion takes priority over a coincident timeout.
        if (i_frame_done) begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
          state_nxt     = ST_IDLE;
        end else if (to_cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + PERIOD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sync_cnt  <= '0;
      to_cnt    <= '0;
      frame_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_cnt  <= sync_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign o_send_sync = (state == ST_SYNC);
  assign o_busy      = (state != ST_IDLE);
  assign o_frame_cnt = frame_cnt;
  assign o_overrun   = overrun;
  assign o_timeout   = timeout_q;
  assign o_dbg_state = state;

endmodule
